// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_t : sequencer FSM states (IDLE, RUN, DONE)
//   OP_ADD / OP_SUB : encoding of the op_sub input
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full-adder cell; the only arithmetic in serial_add_ctrl.
//   a, b : addend bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. One full-adder cell processes a WIDTH-bit
// operation LSB first, one bit per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, op_sub sampled on accept)
//   op_sub              : 0 = a+b, 1 = a-b
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, final carry (sub: 1 = no borrow), signed overflow
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] ra, rb, sum_r;
  logic             carry, cout_r, ovf_r;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s, fa_co;

  assign last = (cnt == CW'(WIDTH - 1));

  full_adder u_fa (
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= (op_sub == OP_SUB) ? ~b : b;
            carry <= (op_sub == OP_SUB);
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_r <= {fa_s, sum_r[WIDTH-1:1]};
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            // carry still holds the carry into the MSB at this point
            ovf_r  <= carry ^ fa_co;
            cout_r <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   acc, res;
  int   acc_cyc[3];
  int   b2b_idx[3];
  bit   will_accept;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_sub   = v.op;
    a        = v.va;
    b        = v.vb;
    @(posedge clk); #1;
    // scramble inputs after accept: they must be ignored
    in_valid = 1'b0;
    op_sub   = ~v.op;
    a        = 8'hA5;
    b        = 8'h5A;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 32'(n), 32'(W));
    check({tag, " sum"},  32'(sum),  32'(v.esum));
    check({tag, " cout"}, 32'(cout), 32'(v.ecout));
    check({tag, " ovf"},  32'(ovf),  32'(v.eovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after handshake"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    //          op    a      b      sum    cout  ovf
    vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'hC8, 8'h64, 8'h64, 1'b1, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    #2;
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum",       32'(sum),       32'd0);
    check("reset cout",      32'(cout),      32'd0);
    check("reset ovf",       32'(ovf),       32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // asynchronous reset in the middle of RUN
    in_valid = 1'b1; op_sub = 1'b0; a = 8'h35; b = 8'h4A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midop in RUN in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midop reset in_ready",  32'(in_ready),  32'd1);
    check("midop reset out_valid", 32'(out_valid), 32'd0);
    check("midop reset sum",       32'(sum),       32'd0);
    #2;
    rst_n = 1'b1;
    run_op('{1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0}, "post-reset 01+01");

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // backpressure: result held, new operands refused
    in_valid = 1'b1; op_sub = 1'b0; a = 8'h35; b = 8'h4A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    check("bp out_valid at DONE", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op_sub   = 1'b1;
      a        = 8'h11 + 8'(i);
      b        = 8'h22;
      @(posedge clk); #1;
      check($sformatf("bp cyc%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp cyc%0d sum", i),       32'(sum),       32'h7F);
      check($sformatf("bp cyc%0d cout", i),      32'(cout),      32'd0);
      check($sformatf("bp cyc%0d in_ready", i),  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release in_ready",  32'(in_ready),  32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp no stray accept in_ready", 32'(in_ready), 32'd1);

    // back-to-back with in_valid and out_ready held high
    b2b_idx[0] = 0; b2b_idx[1] = 3; b2b_idx[2] = 4;
    acc = 0; res = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_sub = vecs[b2b_idx[0]].op; a = vecs[b2b_idx[0]].va; b = vecs[b2b_idx[0]].vb;
    for (int c = 0; c < 60 && res < 3; c++) begin
      will_accept = in_ready && in_valid;
      @(posedge clk); #1;
      if (will_accept) begin
        acc_cyc[acc] = c;
        acc++;
        if (acc < 3) begin
          op_sub = vecs[b2b_idx[acc]].op;
          a      = vecs[b2b_idx[acc]].va;
          b      = vecs[b2b_idx[acc]].vb;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && res < 3) begin
        check($sformatf("b2b%0d sum", res),  32'(sum),  32'(vecs[b2b_idx[res]].esum));
        check($sformatf("b2b%0d cout", res), 32'(cout), 32'(vecs[b2b_idx[res]].ecout));
        check($sformatf("b2b%0d ovf", res),  32'(ovf),  32'(vecs[b2b_idx[res]].eovf));
        res++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b results seen", 32'(res), 32'd3);
    check("b2b accepts seen", 32'(acc), 32'd3);
    if (acc == 3) begin
      check("b2b spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
      check("b2b spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
